// File: rtl/ws28xx_rx.sv
// ============================================================================
// Module   : ws28xx_rx
// Purpose  : WS28xx single-wire line receiver; decodes GRB pixels into RAM writes.
//            Define WS28XX_RX_FWD_EN to forward the line past PIX_MAX pixels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws28xx_rx #(
  parameter int BIT_TH  = 48,
  parameter int RST_CNT = 4000,
  parameter int HI_MAX  = 160,
  parameter int PIX_MAX = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        din_i,
  output logic        dout_o,
  output logic        ram_wr_en_o,
  output logic [7:0]  ram_wr_addr_o,
  output logic [23:0] ram_wr_data_o,
  output logic        frame_done_o,
  output logic [8:0]  pix_cnt_o,
  output logic        err_o
);

  localparam logic [15:0] c_BIT_TH  = 16'(BIT_TH);
  localparam logic [15:0] c_RST_CNT = 16'(RST_CNT);
  localparam logic [15:0] c_HI_MAX  = 16'(HI_MAX);
  localparam logic [8:0]  c_PIX_MAX = 9'(PIX_MAX);

  typedef enum logic [1:0] {
    S_WAIT_RST = 2'd0,
    S_LOW      = 2'd1,
    S_HIGH     = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nx;
  logic         r_sync1;
  logic         r_din_s;
  logic         r_din_d;
  logic [15:0]  r_hi_cnt;
  logic [15:0]  r_lo_cnt;
  logic [4:0]   r_bit_sel;
  logic [8:0]   r_pix_addr;
  logic [22:0]  r_shift;
  logic         r_wr_en;
  logic [7:0]   r_wr_addr;
  logic [23:0]  r_wr_data;
  logic [8:0]   r_pix_cnt;

  logic         w_rise;
  logic         w_fall;
  logic         w_lo_hit;
  logic         w_bit;
  logic [23:0]  w_shift_nx;
  logic         w_shift_en;
  logic         w_clr_frame;
  logic         w_frame_done;
  logic         w_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b0;
      r_din_s <= 1'b0;
      r_din_d <= 1'b0;
    end else begin
      r_sync1 <= din_i;
      r_din_s <= r_sync1;
      r_din_d <= r_din_s;
    end
  end

  assign w_rise     = r_din_s & ~r_din_d;
  assign w_fall     = ~r_din_s & r_din_d;
  assign w_lo_hit   = (r_lo_cnt == c_RST_CNT);
  assign w_bit      = (r_hi_cnt >= c_BIT_TH);
  assign w_shift_nx = {r_shift, w_bit};

  // Each counter runs only while the line sits at its level and saturates.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hi_cnt <= 16'd0;
      r_lo_cnt <= 16'd0;
    end else if (r_din_s) begin
      r_hi_cnt <= (r_hi_cnt == 16'hFFFF) ? r_hi_cnt : r_hi_cnt + 16'd1;
      r_lo_cnt <= 16'd0;
    end else begin
      r_hi_cnt <= 16'd0;
      r_lo_cnt <= (r_lo_cnt == 16'hFFFF) ? r_lo_cnt : r_lo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_WAIT_RST;
    else          r_state <= w_state_nx;
  end

  // Reset detection is evaluated before the rise so a coincident rise opens the new frame.
  always_comb begin
    w_state_nx   = r_state;
    w_shift_en   = 1'b0;
    w_clr_frame  = 1'b0;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_WAIT_RST: begin
        if (w_lo_hit) begin
          w_clr_frame = 1'b1;
          w_state_nx  = w_rise ? S_HIGH : S_LOW;
        end
      end
      S_LOW: begin
        if (w_lo_hit) begin
          w_clr_frame  = 1'b1;
          w_frame_done = (r_pix_addr != 9'd0);
        end
        if (w_rise) w_state_nx = S_HIGH;
      end
      S_HIGH: begin
        if (r_hi_cnt > c_HI_MAX) begin
          w_err       = 1'b1;
          w_clr_frame = 1'b1;
          w_state_nx  = S_WAIT_RST;
        end else if (w_fall) begin
          w_shift_en = 1'b1;
          w_state_nx = S_LOW;
        end
      end
      default: w_state_nx = S_WAIT_RST;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bit_sel  <= 5'd0;
      r_pix_addr <= 9'd0;
      r_shift    <= 23'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 24'd0;
      r_pix_cnt  <= 9'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_frame_done) r_pix_cnt <= r_pix_addr;
      if (w_clr_frame) begin
        r_bit_sel  <= 5'd0;
        r_pix_addr <= 9'd0;
      end else if (w_shift_en) begin
        r_shift <= w_shift_nx[22:0];
        if (r_bit_sel == 5'd23) begin
          r_bit_sel <= 5'd0;
          // Pixels past the frame limit are received but never written.
          if (r_pix_addr < c_PIX_MAX) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_pix_addr[7:0];
            r_wr_data  <= w_shift_nx;
            r_pix_addr <= r_pix_addr + 9'd1;
          end
        end else begin
          r_bit_sel <= r_bit_sel + 5'd1;
        end
      end
    end
  end

`ifdef WS28XX_RX_FWD_EN
  assign dout_o = (r_pix_addr == c_PIX_MAX) & r_din_s;
`else
  assign dout_o = 1'b0;
`endif

  assign ram_wr_en_o   = r_wr_en;
  assign ram_wr_addr_o = r_wr_addr;
  assign ram_wr_data_o = r_wr_data;
  assign frame_done_o  = w_frame_done;
  assign pix_cnt_o     = w_frame_done ? r_pix_addr : r_pix_cnt;
  assign err_o         = w_err;

endmodule

`default_nettype wire

// File: tb/tb_ws28xx_rx.sv
// ============================================================================
// Module   : tb_ws28xx_rx
// Purpose  : Directed self-checking bench for ws28xx_rx (default and PIX_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws28xx_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;

  logic        d_dout, d_wr_en, d_fd, d_err;
  logic [7:0]  d_addr;
  logic [23:0] d_data;
  logic [8:0]  d_pcnt;
  logic        l_dout, l_wr_en, l_fd, l_err;
  logic [7:0]  l_addr;
  logic [23:0] l_data;
  logic [8:0]  l_pcnt;

`ifdef WS28XX_RX_FWD_EN
  localparam int EXP_FWD_RISES = 48;
`else
  localparam int EXP_FWD_RISES = 0;
`endif

  ws28xx_rx dut (
    .clk_i(clk), .rst_n_i(rst_n), .din_i(din), .dout_o(d_dout),
    .ram_wr_en_o(d_wr_en), .ram_wr_addr_o(d_addr), .ram_wr_data_o(d_data),
    .frame_done_o(d_fd), .pix_cnt_o(d_pcnt), .err_o(d_err)
  );

  ws28xx_rx #(.PIX_MAX(4)) dut_lim (
    .clk_i(clk), .rst_n_i(rst_n), .din_i(din), .dout_o(l_dout),
    .ram_wr_en_o(l_wr_en), .ram_wr_addr_o(l_addr), .ram_wr_data_o(l_data),
    .frame_done_o(l_fd), .pix_cnt_o(l_pcnt), .err_o(l_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int last_fall_cyc = 0;

  logic [31:0] wr_q[$];
  int          lat_q[$];
  logic [31:0] lim_q[$];
  int fd_n = 0, err_n = 0, err_lat = 0;
  int lim_fd_n = 0, lim_err_n = 0, lim_rise_n = 0, dut_dout_n = 0;
  logic lim_dout_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_wr_en) begin
      wr_q.push_back({d_addr, d_data});
      lat_q.push_back(cyc - last_fall_cyc);
    end
    if (l_wr_en) lim_q.push_back({l_addr, l_data});
    if (d_fd) fd_n <= fd_n + 1;
    if (d_err) begin
      err_n   <= err_n + 1;
      err_lat <= cyc - last_rise_cyc;
    end
    if (l_fd) lim_fd_n <= lim_fd_n + 1;
    if (l_err) lim_err_n <= lim_err_n + 1;
    if (l_dout && !lim_dout_q) lim_rise_n <= lim_rise_n + 1;
    lim_dout_q <= l_dout;
    if (d_dout) dut_dout_n <= dut_dout_n + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_wr(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] get_lim(input int i);
    return (i < lim_q.size()) ? lim_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int get_lat(input int i);
    return (i < lat_q.size()) ? lat_q[i] : -1;
  endfunction

  // One bit cell: hi cycles high, remainder of per cycles low.
  task automatic send_bit(input int hi, input int per);
    @(negedge clk);
    din = 1'b1;
    last_rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    last_fall_cyc = cyc;
    repeat (per - hi - 1) @(negedge clk);
  endtask

  task automatic send_val(input logic [23:0] v, input int nbits, input int per);
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i] ? 64 : 32, per);
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, l0, f0, e0, lf0, lr0;
    logic [31:0] v;
    logic [23:0] px5 [6];
    px5 = '{24'h000001, 24'h800000, 24'hFFFFFF, 24'h00FF00, 24'hAAAAAA, 24'h555555};

    repeat (5) @(negedge clk);
    check_eq("rst_dout",  d_dout,  0);
    check_eq("rst_wr_en", d_wr_en, 0);
    check_eq("rst_addr",  d_addr,  0);
    check_eq("rst_data",  d_data,  0);
    check_eq("rst_fd",    d_fd,    0);
    check_eq("rst_pcnt",  d_pcnt,  0);
    check_eq("rst_err",   d_err,   0);
    rst_n = 1'b1;

    // Startup frame
    w0 = wr_q.size(); f0 = fd_n; e0 = err_n;
    idle(5000);
    send_val(24'hA5F00F, 24, 100);
    idle(4200);
    check_eq("t1_wr_cnt", wr_q.size() - w0, 1);
    v = get_wr(w0);
    check_eq("t1_addr", v[31:24], 8'd0);
    check_eq("t1_data", v[23:0], 24'hA5F00F);
    check_eq("t1_wr_lat", get_lat(w0), 3);
    check_eq("t1_fd_cnt", fd_n - f0, 1);
    check_eq("t1_pcnt", d_pcnt, 1);
    check_eq("t1_err_cnt", err_n - e0, 0);

    // Threshold: 47 -> 0, 48 -> 1
    w0 = wr_q.size();
    send_bit(47, 100);
    send_bit(48, 100);
    send_val(24'h15A3C3, 22, 100);
    idle(4200);
    check_eq("t2_wr_cnt", wr_q.size() - w0, 1);
    v = get_wr(w0);
    check_eq("t2_thr47", v[23], 1'b0);
    check_eq("t2_thr48", v[22], 1'b1);
    check_eq("t2_data", v[23:0], 24'h55A3C3);
    check_eq("t2_addr", v[31:24], 8'd0);

    // Partial trailing pixel discarded
    w0 = wr_q.size(); f0 = fd_n;
    send_val(24'h123456, 24, 80);
    send_val(24'hFEDCBA, 24, 80);
    send_val(24'h0F0F0F, 24, 80);
    send_val(24'h3FF, 10, 80);
    idle(4200);
    check_eq("t3_wr_cnt", wr_q.size() - w0, 3);
    check_eq("t3_wr0", get_wr(w0),     {8'd0, 24'h123456});
    check_eq("t3_wr1", get_wr(w0 + 1), {8'd1, 24'hFEDCBA});
    check_eq("t3_wr2", get_wr(w0 + 2), {8'd2, 24'h0F0F0F});
    check_eq("t3_fd_cnt", fd_n - f0, 1);
    check_eq("t3_pcnt", d_pcnt, 3);

    // Over-long high pulse mid-pixel
    w0 = wr_q.size(); f0 = fd_n; e0 = err_n;
    send_val(24'hAB, 8, 80);
    send_bit(200, 210);
    send_val(24'h1F, 5, 80);
    idle(4200);
    check_eq("t4_err_cnt", err_n - e0, 1);
    check_eq("t4_err_lat", err_lat, 163);
    check_eq("t4_wr_cnt", wr_q.size() - w0, 0);
    check_eq("t4_fd_cnt", fd_n - f0, 0);
    check_eq("t4_pcnt_hold", d_pcnt, 3);
    send_val(24'hC3C3C3, 24, 80);
    idle(4200);
    check_eq("t4_rec_wr_cnt", wr_q.size() - w0, 1);
    check_eq("t4_rec_wr", get_wr(w0), {8'd0, 24'hC3C3C3});
    check_eq("t4_rec_fd", fd_n - f0, 1);
    check_eq("t4_rec_pcnt", d_pcnt, 1);

    // Frame limit on the PIX_MAX=4 instance
    w0 = wr_q.size(); l0 = lim_q.size(); lf0 = lim_fd_n; lr0 = lim_rise_n;
    for (int p = 0; p < 6; p++) send_val(px5[p], 24, 80);
    idle(4200);
    check_eq("t5_lim_wr_cnt", lim_q.size() - l0, 4);
    for (int p = 0; p < 4; p++)
      check_eq($sformatf("t5_lim_wr%0d", p), get_lim(l0 + p), {8'(p), px5[p]});
    check_eq("t5_lim_pcnt", l_pcnt, 4);
    check_eq("t5_lim_fd", lim_fd_n - lf0, 1);
    check_eq("t5_lim_fwd_rises", lim_rise_n - lr0, EXP_FWD_RISES);
    check_eq("t5_dut_wr_cnt", wr_q.size() - w0, 6);
    check_eq("t5_dut_wr5", get_wr(w0 + 5), {8'd5, 24'h555555});
    check_eq("t5_dut_pcnt", d_pcnt, 6);
    check_eq("t5_dut_dout", dut_dout_n, 0);
    check_eq("t5_lim_err_cnt", lim_err_n, 1);

    // Reset asserted mid-pixel
    send_val(24'hABC, 12, 80);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pcnt", d_pcnt, 0);
    check_eq("t6_rst_addr", d_addr, 0);
    check_eq("t6_rst_data", d_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_q.size(); f0 = fd_n;
    send_val(24'h123DEF, 24, 80);
    idle(20);
    check_eq("t6_no_wr", wr_q.size() - w0, 0);
    idle(4200);
    check_eq("t6_no_fd", fd_n - f0, 0);
    send_val(24'h5A5A5A, 24, 80);
    idle(4200);
    check_eq("t6_wr_cnt", wr_q.size() - w0, 1);
    check_eq("t6_wr", get_wr(w0), {8'd0, 24'h5A5A5A});
    check_eq("t6_fd", fd_n - f0, 1);
    check_eq("t6_pcnt", d_pcnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
